// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch front end: reset vector, PC step,
// queue geometry and FSM state encodings.
package instr_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEF   = 32'd4;
    localparam int unsigned QDEPTH_DEF   = 2;
    localparam int unsigned ENTRY_W      = 64;   // {pc, instr}

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; head is visible
// combinationally so a word pushed at an edge is presented right after it.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic                       valid_o,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch front end: owns the fetch PC, runs the single-outstanding imem request
// FSM and feeds decode from a small queue, flushing on datapath redirects.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_INC   = PC_INC_DEF,
    parameter int unsigned QDEPTH   = QDEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    input  logic        instr_ready
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  addr_q, addr_d;

    logic               q_push, q_pop, q_valid;
    logic [ENTRY_W-1:0] q_head;
    logic [CW-1:0]      q_count;
    logic [CW-1:0]      occ_after;
    logic [31:0]        target_pc;
    logic [31:0]        next_pc;

    assign q_pop     = q_valid && instr_ready;
    assign target_pc = word_align(redirect_pc);
    assign next_pc   = fetch_pc_q + PC_INC;
    assign occ_after = q_count + CW'(1'b1) - CW'(q_pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        q_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target_pc;
                end else if (q_count < QDEPTH_C) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_d = target_pc;
                    state_d    = imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack) begin
                    q_push     = 1'b1;
                    fetch_pc_d = next_pc;
                    // Chain straight into the next request while room remains.
                    if (occ_after < QDEPTH_C) begin
                        state_d = ST_REQ;
                        addr_d  = next_pc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect) fetch_pc_d = target_pc;
                if (imem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .data_i  ({fetch_pc_q, imem_rdata}),
        .pop_i   (q_pop),
        .flush_i (redirect),
        .valid_o (q_valid),
        .data_o  (q_head),
        .count_o (q_count)
    );

    assign imem_req    = (state_q != ST_IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = q_valid;
    assign instr       = q_valid ? q_head[31:0]  : '0;
    assign instr_pc    = q_valid ? q_head[63:32] : '0;
    assign instr_pc4   = q_valid ? (q_head[63:32] + PC_INC) : '0;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: the stimulus pushes expected deliveries,
// a negedge monitor pops and compares every accepted head.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instr_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pc4   (instr_pc4),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, verify its address, then ack it with one word.
    task automatic serve(input logic [31:0] a, input logic [31:0] d, input bit keep);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
        if (!imem_req) return;
        chk("imem_addr", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = d;
        if (keep) sb.push_back('{pc: a, ins: d, pc4: a + 32'd4});
        $display("ack addr=0x%08h data=0x%08h keep=%0d", a, d, keep);
        tick();
        imem_ack = 1'b0;
    endtask

    // Monitor: a head accepted at the coming edge must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc 0x%08h expected none", instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("pop pc=0x%08h instr=0x%08h pc4=0x%08h", instr_pc, instr, instr_pc4);
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.ins);
                chk("instr_pc4", instr_pc4, e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] stream_words [4];
        stream_words[0] = 32'h2001_0005;
        stream_words[1] = 32'h1022_0002;
        stream_words[2] = 32'h0043_0820;
        stream_words[3] = 32'h8C64_0004;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", instr_pc4, 32'h0);
        rst = 1'b0;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Reset asserted while a request is pending acts immediately.
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
        chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rerst_req", {31'd0, imem_req}, 32'd1);
        chk("rerst_addr", imem_addr, 32'h0);

        // Streaming with ready high: back-to-back requests, no gaps.
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(32'(i * 4), stream_words[i], 1'b1);
            chk("stream_nogap", {31'd0, imem_req}, 32'd1);
        end
        tick();

        // Redirect while waiting for an ack: old address held, its data dropped.
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("discard_req", {31'd0, imem_req}, 32'd1);
        chk("discard_addr", imem_addr, 32'h10);
        serve(32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("discard_idle", {31'd0, imem_req}, 32'd0);
        chk("discard_empty", {31'd0, instr_valid}, 32'd0);
        tick();
        serve(32'h40, 32'h1111_1111, 1'b1);

        // Redirect and ack on the same edge: word dropped, restart at aligned target.
        chk("samecyc_addr", imem_addr, 32'h44);
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        redirect = 1'b1; redirect_pc = 32'h0000_0023;
        $display("ack addr=0x%08h data=0x%08h keep=0 redirect=0x%08h", imem_addr, imem_rdata, redirect_pc);
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        chk("samecyc_idle", {31'd0, imem_req}, 32'd0);
        chk("samecyc_empty", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("samecyc_req", {31'd0, imem_req}, 32'd1);
        chk("samecyc_target", imem_addr, 32'h20);

        // Backpressure: queue fills, requests stop, head holds.
        instr_ready = 1'b0;
        serve(32'h20, 32'hAAAA_0001, 1'b1);
        serve(32'h24, 32'hAAAA_0002, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("full_noreq", {31'd0, imem_req}, 32'd0);
            chk("full_head_pc", instr_pc, 32'h20);
            tick();
        end
        // Stray ack while idle must not push anything.
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        chk("idle_ack_noreq", {31'd0, imem_req}, 32'd0);
        chk("idle_ack_head", instr, 32'hAAAA_0001);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pop_noreq_yet", {31'd0, imem_req}, 32'd0);
        tick();
        chk("after_pop_req", {31'd0, imem_req}, 32'd1);
        chk("after_pop_addr", imem_addr, 32'h28);
        chk("after_pop_head", instr_pc, 32'h24);
        serve(32'h28, 32'hAAAA_0003, 1'b1);
        instr_ready = 1'b1;
        tick(); tick(); tick();
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h2C);

        // Wrap-around at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        serve(32'h2C, 32'h5555_5555, 1'b0);
        tick();
        serve(32'hFFFF_FFFC, 32'h0C00_0010, 1'b1);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);
        tick(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
